trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter: TIMER_CAUSE, 32'h8000_0007, mcause value written for the timer interrupt.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: ecall_i  input  1  one-cycle pulse, ECALL decoded in the current instruction.
REQ-005 SHALL have port: ebreak_i  input  1  one-cycle pulse, EBREAK decoded.
REQ-006 SHALL have port: mret_i  input  1  one-cycle pulse, MRET decoded.
REQ-007 SHALL have port: int_req_i  input  1  level timer interrupt request.
REQ-008 SHALL have port: inst_addr_i  input  32  address of the current instruction.
REQ-009 SHALL have port: jump_flag_i  input  1  ex is redirecting the PC this cycle.
REQ-010 SHALL have port: jump_addr_i  input  32  ex redirect target.
REQ-011 SHALL have port: csr_mtvec_i, csr_mepc_i, csr_mstatus_i  input  32 each  current CSR values.
REQ-012 SHALL have port: csr_we_o  output  1  CSR write enable (CSR file clint write port).
REQ-013 SHALL have port: csr_waddr_o  output  32  CSR write address, bits [31:12] zero.
REQ-014 SHALL have port: csr_data_o  output  32  CSR write data.
REQ-015 SHALL have port: hold_flag_o  output  1  pipeline hold request.
REQ-016 SHALL have port: int_assert_o  output  1  one-cycle PC redirect pulse.
REQ-017 SHALL have port: int_addr_o  output  32  redirect target, valid when int_assert_o=1.

Function
REQ-018 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MSTATUS_MRET, ASSERT.
REQ-019 In IDLE, request priority SHALL be: ecall/ebreak > mret > int_req_i; int_req_i SHALL be taken only if csr_mstatus_i[3]=1.
REQ-020 On accepting a trap in IDLE (cycle N), the block SHALL latch cause (ecall 32'd11, ebreak 32'd3, interrupt TIMER_CAUSE) and return address, then go to W_MEPC.
REQ-021 Return address SHALL be inst_addr_i for ecall/ebreak; for interrupt, jump_addr_i if jump_flag_i=1, else inst_addr_i.
REQ-022 W_MEPC (N+1) SHALL drive csr_we_o=1, csr_waddr_o=0x341, data = latched address; next W_MCAUSE.
REQ-023 W_MCAUSE (N+2) SHALL write 0x342 with latched cause; next W_MSTATUS.
REQ-024 W_MSTATUS (N+3) SHALL write 0x300 with csr_mstatus_i, bit7 (MPIE) = old bit3, bit3 (MIE) = 0; next ASSERT.
REQ-025 On accepting mret in IDLE (cycle N), the FSM SHALL go to W_MSTATUS_MRET (N+1), write 0x300 with bit3 = old bit7, bit7 = 1, then go to ASSERT.
REQ-026 ASSERT SHALL pulse int_assert_o=1 for one cycle with int_addr_o = csr_mtvec_i (trap) or csr_mepc_i (mret), then return to IDLE.
REQ-027 hold_flag_o SHALL be 1 combinationally in the accepting IDLE cycle and in every non-IDLE state; 0 otherwise.
REQ-028 Outside write states csr_we_o, csr_waddr_o and csr_data_o SHALL be 0; outside ASSERT int_assert_o and int_addr_o SHALL be 0.
REQ-029 Requests arriving while not in IDLE SHALL be ignored; a level int_req_i still high on return to IDLE SHALL be re-evaluated against the updated MIE.
REQ-030 Simultaneous ecall and ebreak SHALL take ecall; simultaneous sync exception and int_req_i SHALL take the exception, leaving the interrupt pending.

Reset
REQ-031 With rst=1 at a posedge, state SHALL become IDLE and latches SHALL clear; all outputs SHALL be 0 at the next cycle, including mid-sequence (remaining CSR writes abandoned).

Verification
REQ-032 ecall_i at inst_addr 0x100, mtvec 0x200 -> writes 0x341=0x100, 0x342=11, 0x300 (MIE cleared); int_assert at N+4 to 0x200; hold N..N+4.
REQ-033 int_req_i=1, mstatus=0x8, jump_flag_i=1, jump_addr 0x480 -> mepc=0x480, mcause=0x80000007, mstatus=0x80, redirect to mtvec.
REQ-034 int_req_i=1, mstatus=0x0 -> no writes, hold_flag_o=0 indefinitely.
REQ-035 mret_i, mstatus=0x80, mepc=0x104 -> N+1 writes 0x300=0x88; N+2 int_assert to 0x104.
REQ-036 ecall_i with int_req_i=1, MIE=1 -> ecall sequence first (mcause=11, MIE cleared); interrupt not taken until MIE re-set.
REQ-037 rst pulsed during W_MCAUSE -> no mcause/mstatus write, no int_assert, IDLE with all outputs 0.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the core pipeline and the trap controller.
// The core side drives requests and CSR values; the trap controller drives the CSR write port and PC redirect.
interface trap_ctrl_if;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic        int_req_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  modport master (
    output ecall_i, ebreak_i, mret_i, int_req_i, inst_addr_i, jump_flag_i,
           jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  csr_we_o, csr_waddr_o, csr_data_o, hold_flag_o, int_assert_o, int_addr_o
  );

  modport slave (
    input  ecall_i, ebreak_i, mret_i, int_req_i, inst_addr_i, jump_flag_i,
           jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output csr_we_o, csr_waddr_o, csr_data_o, hold_flag_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/ebreak/timer interrupt/mret, writes mepc/mcause/mstatus
// one CSR per cycle, then pulses a PC redirect to mtvec (trap) or mepc (return).
module trap_ctrl #(
  parameter logic [31:0] TIMER_CAUSE = 32'h8000_0007
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    W_MEPC         = 3'd1,
    W_MCAUSE       = 3'd2,
    W_MSTATUS      = 3'd3,
    W_MSTATUS_MRET = 3'd4,
    ASSERT         = 3'd5
  } state_e;

  state_e      state_r, state_nxt_s;
  logic [31:0] cause_r, cause_nxt_s;
  logic [31:0] addr_r, addr_nxt_s;
  logic        mret_r, mret_nxt_s;

  logic        take_sync_s;
  logic        take_int_s;
  logic        csr_we_s;
  logic [31:0] csr_waddr_s;
  logic [31:0] csr_data_s;
  logic        hold_s;
  logic        int_assert_s;
  logic [31:0] int_addr_s;

  // Trap entry: stack MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Request qualification; an interrupt is only eligible while MIE is set.
  always_comb begin
    take_sync_s = bus.ecall_i | bus.ebreak_i;
    take_int_s  = bus.int_req_i & bus.csr_mstatus_i[3];
  end

  // Next-state, latch updates and all outputs decoded from the current state.
  always_comb begin
    state_nxt_s  = state_r;
    cause_nxt_s  = cause_r;
    addr_nxt_s   = addr_r;
    mret_nxt_s   = mret_r;
    csr_we_s     = 1'b0;
    csr_waddr_s  = 32'h0000_0000;
    csr_data_s   = 32'h0000_0000;
    hold_s       = 1'b0;
    int_assert_s = 1'b0;
    int_addr_s   = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (take_sync_s) begin
          hold_s      = 1'b1;
          state_nxt_s = W_MEPC;
          cause_nxt_s = bus.ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
          addr_nxt_s  = bus.inst_addr_i;
          mret_nxt_s  = 1'b0;
        end else if (bus.mret_i) begin
          hold_s      = 1'b1;
          state_nxt_s = W_MSTATUS_MRET;
          mret_nxt_s  = 1'b1;
        end else if (take_int_s) begin
          // A redirect in flight means the interrupted instruction is the jump target.
          hold_s      = 1'b1;
          state_nxt_s = W_MEPC;
          cause_nxt_s = TIMER_CAUSE;
          addr_nxt_s  = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
          mret_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      W_MEPC: begin
        hold_s      = 1'b1;
        csr_we_s    = 1'b1;
        csr_waddr_s = CSR_MEPC;
        csr_data_s  = addr_r;
        state_nxt_s = W_MCAUSE;
      end
      W_MCAUSE: begin
        hold_s      = 1'b1;
        csr_we_s    = 1'b1;
        csr_waddr_s = CSR_MCAUSE;
        csr_data_s  = cause_r;
        state_nxt_s = W_MSTATUS;
      end
      W_MSTATUS: begin
        hold_s      = 1'b1;
        csr_we_s    = 1'b1;
        csr_waddr_s = CSR_MSTATUS;
        csr_data_s  = mstatus_on_trap(bus.csr_mstatus_i);
        state_nxt_s = ASSERT;
      end
      W_MSTATUS_MRET: begin
        hold_s      = 1'b1;
        csr_we_s    = 1'b1;
        csr_waddr_s = CSR_MSTATUS;
        csr_data_s  = mstatus_on_mret(bus.csr_mstatus_i);
        state_nxt_s = ASSERT;
      end
      ASSERT: begin
        hold_s       = 1'b1;
        int_assert_s = 1'b1;
        int_addr_s   = mret_r ? bus.csr_mepc_i : bus.csr_mtvec_i;
        state_nxt_s  = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and trap-context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cause_r <= 32'h0000_0000;
      addr_r  <= 32'h0000_0000;
      mret_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
      addr_r  <= addr_nxt_s;
      mret_r  <= mret_nxt_s;
    end
  end

  assign bus.csr_we_o     = csr_we_s;
  assign bus.csr_waddr_o  = csr_waddr_s;
  assign bus.csr_data_o   = csr_data_s;
  assign bus.hold_flag_o  = hold_s;
  assign bus.int_assert_o = int_assert_s;
  assign bus.int_addr_o   = int_addr_s;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: each scenario task drives a request and checks every output per cycle.
module tb_trap_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [98:0] exp_v;

  trap_ctrl_if bus ();

  trap_ctrl #(.TIMER_CAUSE(32'h8000_0007)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output snapshot: {hold, we, waddr, data, int_assert, int_addr}.
  function automatic logic [98:0] outs();
    return {bus.hold_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_data_o,
            bus.int_assert_o, bus.int_addr_o};
  endfunction

  function automatic logic [98:0] pk(input logic h, input logic we, input logic [31:0] wa,
                                     input logic [31:0] wd, input logic ia, input logic [31:0] iaddr);
    return {h, we, wa, wd, ia, iaddr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.ecall_i       = 1'b0;
    bus.ebreak_i      = 1'b0;
    bus.mret_i        = 1'b0;
    bus.int_req_i     = 1'b0;
    bus.inst_addr_i   = 32'h0000_0000;
    bus.jump_flag_i   = 1'b0;
    bus.jump_addr_i   = 32'h0000_0000;
    bus.csr_mtvec_i   = 32'h0000_0200;
    bus.csr_mepc_i    = 32'h0000_0000;
    bus.csr_mstatus_i = 32'h0000_0000;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL reset got=%h exp=%h", outs(), exp_v); end
  endtask

  task automatic test_ecall();
    tick();
    bus.ecall_i = 1'b1; bus.inst_addr_i = 32'h100; bus.csr_mstatus_i = 32'h8; #1;
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_accept got=%h exp=%h", outs(), exp_v); end
    tick(); bus.ecall_i = 1'b0; bus.inst_addr_i = 32'h104; #1;
    exp_v = pk(1'b1, 1'b1, 32'h341, 32'h100, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_mepc got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_mcause got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_mstatus got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h80;
    tick();
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_assert got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ecall_idle got=%h exp=%h", outs(), exp_v); end
  endtask

  task automatic test_ebreak_over_mret();
    quiet_inputs();
    tick();
    bus.ebreak_i = 1'b1; bus.mret_i = 1'b1; bus.inst_addr_i = 32'h40; #1;
    tick(); bus.ebreak_i = 1'b0; bus.mret_i = 1'b0; #1;
    exp_v = pk(1'b1, 1'b1, 32'h341, 32'h40, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ebreak_mepc got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'd3, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ebreak_mcause got=%h exp=%h", outs(), exp_v); end
    tick(); tick();
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL ebreak_assert got=%h exp=%h", outs(), exp_v); end
    tick();
  endtask

  task automatic test_int_jump();
    quiet_inputs();
    tick();
    bus.int_req_i = 1'b1; bus.csr_mstatus_i = 32'h8; bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h480; bus.inst_addr_i = 32'h500; #1;
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL int_accept got=%h exp=%h", outs(), exp_v); end
    tick(); bus.int_req_i = 1'b0; bus.jump_flag_i = 1'b0; bus.jump_addr_i = 32'h0; #1;
    exp_v = pk(1'b1, 1'b1, 32'h341, 32'h480, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL int_mepc got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'h8000_0007, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL int_mcause got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL int_mstatus got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h80;
    tick();
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL int_assert got=%h exp=%h", outs(), exp_v); end
    tick();
  endtask

  task automatic test_int_masked();
    quiet_inputs();
    bus.int_req_i = 1'b1; bus.csr_mstatus_i = 32'h0; bus.inst_addr_i = 32'h600;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
      if (outs() !== exp_v) begin miscompares++; $display("FAIL int_masked cyc%0d got=%h exp=%h", i, outs(), exp_v); end
    end
    bus.int_req_i = 1'b0;
  endtask

  task automatic test_mret();
    quiet_inputs();
    tick();
    bus.mret_i = 1'b1; bus.csr_mstatus_i = 32'h80; bus.csr_mepc_i = 32'h104; #1;
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL mret_accept got=%h exp=%h", outs(), exp_v); end
    tick(); bus.mret_i = 1'b0; #1;
    exp_v = pk(1'b1, 1'b1, 32'h300, 32'h88, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL mret_mstatus got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h88;
    tick();
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL mret_assert got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL mret_idle got=%h exp=%h", outs(), exp_v); end
  endtask

  task automatic test_back_to_back();
    quiet_inputs();
    tick();
    bus.ecall_i = 1'b1; bus.ebreak_i = 1'b1; bus.int_req_i = 1'b1;
    bus.csr_mstatus_i = 32'h8; bus.inst_addr_i = 32'h300; #1;
    tick(); bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b1; #1;
    exp_v = pk(1'b1, 1'b1, 32'h341, 32'h300, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_mepc got=%h exp=%h", outs(), exp_v); end
    tick(); bus.mret_i = 1'b0; #1;
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_mcause got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_mstatus got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h80;
    tick();
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_assert got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_pending_masked got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h88; bus.inst_addr_i = 32'h304; #1;
    exp_v = pk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_pending_taken got=%h exp=%h", outs(), exp_v); end
    tick(); bus.int_req_i = 1'b0; #1;
    exp_v = pk(1'b1, 1'b1, 32'h341, 32'h304, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_int_mepc got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'h8000_0007, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_int_mcause got=%h exp=%h", outs(), exp_v); end
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL prio_int_mstatus got=%h exp=%h", outs(), exp_v); end
    bus.csr_mstatus_i = 32'h80;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    quiet_inputs();
    tick();
    bus.ecall_i = 1'b1; bus.inst_addr_i = 32'h700; bus.csr_mstatus_i = 32'h8; #1;
    tick(); bus.ecall_i = 1'b0; #1;
    tick();
    exp_v = pk(1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL rstmid_mcause got=%h exp=%h", outs(), exp_v); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
    if (outs() !== exp_v) begin miscompares++; $display("FAIL rstmid_idle got=%h exp=%h", outs(), exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = pk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); vectors++;
      if (outs() !== exp_v) begin miscompares++; $display("FAIL rstmid_quiet cyc%0d got=%h exp=%h", i, outs(), exp_v); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    quiet_inputs();
    test_reset();
    test_ecall();
    test_ebreak_over_mret();
    test_int_jump();
    test_int_masked();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
